// File: rtl/mig_burst_ctrl.sv
// mig_burst_ctrl
//   Converts one cache-line request into a MIG (DDR2) burst. A write sends one
//   address/command and BEATS write-data beats. A read sends one read command,
//   then collects BEATS returned beats, or stops early on a timeout.
//
// Ports
//   clk, rst_n           single clock; asynchronous active-low reset
//   req_*                cache request (valid/ready, we, addr, line data, byte mask)
//   rsp_*                one-cycle completion pulse, timeout flag, read line
//   app_af_*             MIG address/command FIFO (almost-full in, strobe/addr/cmd out)
//   app_wdf_*            MIG write-data FIFO (almost-full in, strobe/beat/mask out)
//   rd_data_valid,
//   rd_data_fifo_out     MIG read-return beats
module mig_burst_ctrl #(
  parameter int APPDATA_WIDTH = 128,
  parameter int BEATS         = 2,
  parameter int ADDR_WIDTH    = 31,
  parameter int TIMEOUT       = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_we,
  input  logic [ADDR_WIDTH-1:0]             req_addr,
  input  logic [BEATS*APPDATA_WIDTH-1:0]    req_wdata,
  input  logic [BEATS*APPDATA_WIDTH/8-1:0]  req_wmask,
  output logic                              rsp_valid,
  output logic                              rsp_err,
  output logic [BEATS*APPDATA_WIDTH-1:0]    rsp_rdata,
  input  logic                              app_af_afull,
  input  logic                              app_wdf_afull,
  output logic                              app_af_wren,
  output logic [ADDR_WIDTH-1:0]             app_af_addr,
  output logic [2:0]                        app_af_cmd,
  output logic                              app_wdf_wren,
  output logic [APPDATA_WIDTH-1:0]          app_wdf_data,
  output logic [APPDATA_WIDTH/8-1:0]        app_wdf_mask_data,
  input  logic                              rd_data_valid,
  input  logic [APPDATA_WIDTH-1:0]          rd_data_fifo_out
);

  localparam int MW = APPDATA_WIDTH / 8;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0]    CMD_WR    = 3'b000;
  localparam logic [2:0]    CMD_RD    = 3'b001;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WRITE, RD_CMD, RD_WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]                addr_q;
  logic [BEATS-1:0][APPDATA_WIDTH-1:0]  wdata_q;
  logic [BEATS-1:0][MW-1:0]             wmask_q;
  logic [BEATS-1:0][APPDATA_WIDTH-1:0]  rdata_q;
  logic [BW-1:0]                        beat;
  logic [TW-1:0]                        tcnt;
  logic                                 err_q;

  logic w_fire, last, tout, tout_err;

  assign req_ready = (state == IDLE);
  assign rsp_rdata = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    last      = (beat == LAST_BEAT);
    tout      = (tcnt == TOUT_LAST);
    w_fire    = 1'b0;
    tout_err  = 1'b0;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_we ? WRITE : RD_CMD;
      WRITE: begin
        // The command rides with beat 0, so only beat 0 waits for the address FIFO.
        w_fire = !app_wdf_afull && ((beat != '0) || !app_af_afull);
        if (w_fire && last) state_nxt = RESP;
      end
      RD_CMD:  if (!app_af_afull) state_nxt = RD_WAIT;
      RD_WAIT: begin
        // A final beat landing on the timeout edge completes cleanly.
        if (rd_data_valid && last) state_nxt = RESP;
        else if (tout) begin
          state_nxt = RESP;
          tout_err  = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q            <= '0;
      wdata_q           <= '0;
      wmask_q           <= '0;
      rdata_q           <= '0;
      beat              <= '0;
      tcnt              <= '0;
      err_q             <= 1'b0;
      app_af_wren       <= 1'b0;
      app_af_addr       <= '0;
      app_af_cmd        <= '0;
      app_wdf_wren      <= 1'b0;
      app_wdf_data      <= '0;
      app_wdf_mask_data <= '0;
      rsp_valid         <= 1'b0;
      rsp_err           <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared every edge unless re-asserted below.
      app_af_wren  <= 1'b0;
      app_wdf_wren <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          wmask_q <= req_wmask;
          beat    <= '0;
          tcnt    <= '0;
          err_q   <= 1'b0;
          if (!req_we) rdata_q <= '0;
        end
        WRITE: if (w_fire) begin
          app_wdf_wren      <= 1'b1;
          app_wdf_data      <= wdata_q[beat];
          app_wdf_mask_data <= wmask_q[beat];
          beat              <= beat + 1'b1;
          if (beat == '0) begin
            app_af_wren <= 1'b1;
            app_af_cmd  <= CMD_WR;
            app_af_addr <= addr_q;
          end
        end
        RD_CMD: if (!app_af_afull) begin
          app_af_wren <= 1'b1;
          app_af_cmd  <= CMD_RD;
          app_af_addr <= addr_q;
          tcnt        <= '0;
        end
        RD_WAIT: begin
          if (rd_data_valid) begin
            rdata_q[beat] <= rd_data_fifo_out;
            beat          <= beat + 1'b1;
            tcnt          <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
          if (tout_err) err_q <= 1'b1;
        end
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mig_burst_ctrl.sv
// Directed bench: a BEATS=2 instance for write paths and a BEATS=4 instance for
// read, timeout and busy-request paths; both with TIMEOUT=16, 32-bit beats.
module tb_mig_burst_ctrl;

  localparam int DW = 32;
  localparam int AW = 31;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // write-side instance (BEATS=2)
  logic            w_req_valid, w_req_ready, w_req_we;
  logic [AW-1:0]   w_req_addr;
  logic [2*DW-1:0] w_req_wdata, w_rsp_rdata;
  logic [7:0]      w_req_wmask;
  logic            w_rsp_valid, w_rsp_err, w_af_afull, w_wdf_afull, w_af_wren, w_wdf_wren;
  logic [AW-1:0]   w_af_addr;
  logic [2:0]      w_af_cmd;
  logic [DW-1:0]   w_wdf_data, w_rd_data;
  logic [3:0]      w_wdf_mask;
  logic            w_rd_valid;

  // read-side instance (BEATS=4)
  logic            r_req_valid, r_req_ready, r_req_we;
  logic [AW-1:0]   r_req_addr;
  logic [4*DW-1:0] r_req_wdata, r_rsp_rdata;
  logic [15:0]     r_req_wmask;
  logic            r_rsp_valid, r_rsp_err, r_af_afull, r_wdf_afull, r_af_wren, r_wdf_wren;
  logic [AW-1:0]   r_af_addr;
  logic [2:0]      r_af_cmd;
  logic [DW-1:0]   r_wdf_data, r_rd_data;
  logic [3:0]      r_wdf_mask;
  logic            r_rd_valid;

  mig_burst_ctrl #(.APPDATA_WIDTH(DW), .BEATS(2), .ADDR_WIDTH(AW), .TIMEOUT(16)) u_w (
    .clk(clk), .rst_n(rst_n),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_we(w_req_we),
    .req_addr(w_req_addr), .req_wdata(w_req_wdata), .req_wmask(w_req_wmask),
    .rsp_valid(w_rsp_valid), .rsp_err(w_rsp_err), .rsp_rdata(w_rsp_rdata),
    .app_af_afull(w_af_afull), .app_wdf_afull(w_wdf_afull),
    .app_af_wren(w_af_wren), .app_af_addr(w_af_addr), .app_af_cmd(w_af_cmd),
    .app_wdf_wren(w_wdf_wren), .app_wdf_data(w_wdf_data), .app_wdf_mask_data(w_wdf_mask),
    .rd_data_valid(w_rd_valid), .rd_data_fifo_out(w_rd_data)
  );

  mig_burst_ctrl #(.APPDATA_WIDTH(DW), .BEATS(4), .ADDR_WIDTH(AW), .TIMEOUT(16)) u_r (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r_req_valid), .req_ready(r_req_ready), .req_we(r_req_we),
    .req_addr(r_req_addr), .req_wdata(r_req_wdata), .req_wmask(r_req_wmask),
    .rsp_valid(r_rsp_valid), .rsp_err(r_rsp_err), .rsp_rdata(r_rsp_rdata),
    .app_af_afull(r_af_afull), .app_wdf_afull(r_wdf_afull),
    .app_af_wren(r_af_wren), .app_af_addr(r_af_addr), .app_af_cmd(r_af_cmd),
    .app_wdf_wren(r_wdf_wren), .app_wdf_data(r_wdf_data), .app_wdf_mask_data(r_wdf_mask),
    .rd_data_valid(r_rd_valid), .rd_data_fifo_out(r_rd_data)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [4*DW-1:0] RLINE = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};

  initial begin
    rst_n = 1'b0;
    w_req_valid = 0; w_req_we = 0; w_req_addr = '0; w_req_wdata = '0; w_req_wmask = '0;
    w_af_afull = 0; w_wdf_afull = 0; w_rd_valid = 0; w_rd_data = '0;
    r_req_valid = 0; r_req_we = 0; r_req_addr = '0; r_req_wdata = '0; r_req_wmask = '0;
    r_af_afull = 0; r_wdf_afull = 0; r_rd_valid = 0; r_rd_data = '0;
    step(); step();

    // ---- reset state
    chk("rst_ready", w_req_ready, 1'b1);
    chk("rst_af_wren", w_af_wren, 1'b0);
    chk("rst_wdf_wren", w_wdf_wren, 1'b0);
    chk("rst_rsp_valid", r_rsp_valid, 1'b0);
    chk("rst_rdata", r_rsp_rdata, '0);
    chk("rst_af_addr", w_af_addr, '0);
    rst_n = 1'b1;
    step();

    // ---- unstalled write, BEATS=2
    w_req_valid = 1; w_req_we = 1; w_req_addr = 31'h100;
    w_req_wdata = {32'hBBBB0001, 32'hAAAA0000}; w_req_wmask = 8'h00;
    chk("w1_ready_idle", w_req_ready, 1'b1);
    step();                                   // N
    w_req_valid = 0;
    chk("w1_ready_busy", w_req_ready, 1'b0);
    chk("w1_af_wren_n", w_af_wren, 1'b0);
    step();                                   // N+1
    chk("w1_af_wren", w_af_wren, 1'b1);
    chk("w1_af_cmd", w_af_cmd, 3'b000);
    chk("w1_af_addr", w_af_addr, 31'h100);
    chk("w1_wren_b0", w_wdf_wren, 1'b1);
    chk("w1_data_b0", w_wdf_data, 32'hAAAA0000);
    chk("w1_mask_b0", w_wdf_mask, 4'h0);
    step();                                   // N+2
    chk("w1_af_wren_off", w_af_wren, 1'b0);
    chk("w1_wren_b1", w_wdf_wren, 1'b1);
    chk("w1_data_b1", w_wdf_data, 32'hBBBB0001);
    chk("w1_rsp_early", w_rsp_valid, 1'b0);
    step();                                   // N+3
    chk("w1_rsp_valid", w_rsp_valid, 1'b1);
    chk("w1_rsp_err", w_rsp_err, 1'b0);
    chk("w1_wren_off", w_wdf_wren, 1'b0);
    chk("w1_ready_back", w_req_ready, 1'b1);
    step();
    chk("w1_rsp_pulse", w_rsp_valid, 1'b0);

    // ---- write with af stall on beat 0, then wdf stall for 3 cycles
    w_req_valid = 1; w_req_we = 1; w_req_addr = 31'h1F0;
    w_req_wdata = {32'h22220002, 32'h11110001}; w_req_wmask = 8'h5A;
    w_af_afull = 1;
    step();                                   // N
    w_req_valid = 0;
    step();                                   // N+1: blocked by af_afull
    chk("w2_af_stall_wdf", w_wdf_wren, 1'b0);
    chk("w2_af_stall_af", w_af_wren, 1'b0);
    w_af_afull = 0;
    step();                                   // N+2: beat 0
    chk("w2_af_wren", w_af_wren, 1'b1);
    chk("w2_af_addr", w_af_addr, 31'h1F0);
    chk("w2_wren_b0", w_wdf_wren, 1'b1);
    chk("w2_data_b0", w_wdf_data, 32'h11110001);
    chk("w2_mask_b0", w_wdf_mask, 4'hA);
    w_wdf_afull = 1;
    for (int i = 0; i < 3; i++) begin         // N+3..N+5 stalled
      step();
      chk("w2_stall_wdf", w_wdf_wren, 1'b0);
      chk("w2_stall_af", w_af_wren, 1'b0);
      chk("w2_stall_hold", w_wdf_data, 32'h11110001);
    end
    w_wdf_afull = 0; w_af_afull = 1;          // af_afull must not block beat 1
    step();                                   // N+6
    chk("w2_wren_b1", w_wdf_wren, 1'b1);
    chk("w2_data_b1", w_wdf_data, 32'h22220002);
    chk("w2_mask_b1", w_wdf_mask, 4'h5);
    chk("w2_no_dup_af", w_af_wren, 1'b0);
    w_af_afull = 0;
    step();                                   // N+7
    chk("w2_no_dup_wdf", w_wdf_wren, 1'b0);
    chk("w2_rsp_valid", w_rsp_valid, 1'b1);

    // ---- read BEATS=4 with gaps; req_valid held so a write queues behind it
    r_req_valid = 1; r_req_we = 0; r_req_addr = 31'h2000;
    step();                                   // N
    r_req_we = 1; r_req_wdata = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    chk("r1_ready_busy", r_req_ready, 1'b0);
    step();                                   // N+1
    chk("r1_af_wren", r_af_wren, 1'b1);
    chk("r1_af_cmd", r_af_cmd, 3'b001);
    chk("r1_af_addr", r_af_addr, 31'h2000);
    r_rd_valid = 1; r_rd_data = 32'hD0D0D0D0;
    step();                                   // N+2: D0
    r_rd_valid = 0;
    chk("r1_af_pulse", r_af_wren, 1'b0);
    chk("r1_pending", r_req_ready, 1'b0);
    step();
    r_rd_valid = 1; r_rd_data = 32'hD1D1D1D1;
    step();                                   // N+4: D1
    r_rd_valid = 0;
    step();
    r_rd_valid = 1; r_rd_data = 32'hD2D2D2D2;
    step();                                   // N+6: D2
    r_rd_data = 32'hD3D3D3D3;
    step();                                   // N+7: D3
    r_rd_valid = 0;
    chk("r1_rsp_early", r_rsp_valid, 1'b0);
    chk("r1_pending2", r_req_ready, 1'b0);
    step();                                   // N+8
    chk("r1_rsp_valid", r_rsp_valid, 1'b1);
    chk("r1_rsp_err", r_rsp_err, 1'b0);
    chk("r1_rdata", r_rsp_rdata, RLINE);
    step();                                   // N+9: queued write accepted
    r_req_valid = 0;
    chk("r1_rsp_pulse", r_rsp_valid, 1'b0);
    chk("r1_second_busy", r_req_ready, 1'b0);
    step();                                   // N+10
    chk("r1_wr_af_wren", r_af_wren, 1'b1);
    chk("r1_wr_af_cmd", r_af_cmd, 3'b000);
    chk("r1_wr_data_b0", r_wdf_data, 32'h11111111);
    repeat (3) step();                        // N+13
    chk("r1_wr_data_b3", r_wdf_data, 32'h44444444);
    step();                                   // N+14
    chk("r1_wr_rsp", r_rsp_valid, 1'b1);
    chk("r1_wr_keeps_rdata", r_rsp_rdata, RLINE);
    r_rd_valid = 1; r_rd_data = 32'hDEADBEEF;  // stray beat in IDLE
    step();
    r_rd_valid = 0;
    chk("r1_stray_rdata", r_rsp_rdata, RLINE);
    chk("r1_stray_ready", r_req_ready, 1'b1);
    chk("r1_stray_rsp", r_rsp_valid, 1'b0);

    // ---- timeout after one beat
    r_req_valid = 1; r_req_we = 0; r_req_addr = 31'h3000;
    step();                                   // N
    r_req_valid = 0;
    chk("r2_rdata_clear", r_rsp_rdata, '0);
    step();                                   // N+1
    r_rd_valid = 1; r_rd_data = 32'h0000A5A5;
    step();                                   // E: D0 stored
    r_rd_valid = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("r2_no_rsp_yet", r_rsp_valid, 1'b0);
    end
    step();                                   // E+17
    chk("r2_tout_valid", r_rsp_valid, 1'b1);
    chk("r2_tout_err", r_rsp_err, 1'b1);
    chk("r2_tout_rdata", r_rsp_rdata, {96'h0, 32'h0000A5A5});

    // ---- last beat arriving on the timeout edge completes without error
    r_req_valid = 1; r_req_we = 0; r_req_addr = 31'h4000;
    step();                                   // N
    r_req_valid = 0;
    step();                                   // N+1
    r_rd_valid = 1; r_rd_data = 32'hE0E0E0E0;
    step();
    r_rd_data = 32'hE1E1E1E1;
    step();
    r_rd_data = 32'hE2E2E2E2;
    step();                                   // E: third beat
    r_rd_valid = 0;
    repeat (15) step();                       // E+15
    r_rd_valid = 1; r_rd_data = 32'hE3E3E3E3;
    step();                                   // E+16: timeout edge + last beat
    r_rd_valid = 0;
    chk("r3_rsp_early", r_rsp_valid, 1'b0);
    step();
    chk("r3_rsp_valid", r_rsp_valid, 1'b1);
    chk("r3_err", r_rsp_err, 1'b0);
    chk("r3_rdata", r_rsp_rdata, {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0});

    // ---- asynchronous reset mid-write
    w_req_valid = 1; w_req_we = 1; w_req_addr = 31'h55;
    w_req_wdata = {32'h99999999, 32'h88888888}; w_req_wmask = 8'hFF;
    step();                                   // N
    w_req_valid = 0;
    step();                                   // N+1: beat 0 out
    chk("rs_b0_wren", w_wdf_wren, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rs_af_wren", w_af_wren, 1'b0);
    chk("rs_wdf_wren", w_wdf_wren, 1'b0);
    chk("rs_wdf_data", w_wdf_data, '0);
    chk("rs_wdf_mask", w_wdf_mask, '0);
    chk("rs_af_addr", w_af_addr, '0);
    step();
    rst_n = 1'b1;
    step();
    chk("rs_ready", w_req_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rs_quiet_wdf", w_wdf_wren, 1'b0);
      chk("rs_quiet_af", w_af_wren, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
